tjmono_ab_scheduler: RTL and testbench

TJMONO_AB_SCHEDULER -- requirements
Module: tjmono_ab_scheduler

---
 rtl/tjmono_pkg.sv | 17 +
 rtl/tjmono_ab_scheduler_if.sv | 27 ++
 rtl/tjmono_rr2.sv | 20 ++
 rtl/tjmono_ab_scheduler.sv | 134 +++++++++++++
 tb/tb_tjmono_ab_scheduler.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tjmono_pkg.sv
// Shared definitions for the TJ-Monopix A/B half-matrix readout scheduler.
package tjmono_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FREEZE   = 3'd1,
    ST_READ_HI  = 3'd2,
    ST_READ_LO  = 3'd3,
    ST_DECIDE   = 3'd4,
    ST_UNFREEZE = 3'd5
  } sched_state_t;

  // Cycles FREEZE is held before the first READ of a frame.
  localparam int FREEZE_SETUP = 2;
  localparam int FW_W         = 8;

endpackage

// File: rtl/tjmono_ab_scheduler_if.sv
// Configuration, token/backpressure inputs and chip-control outputs of the A/B scheduler.
interface tjmono_ab_scheduler_if #(
  parameter int READ_GAP_W = 6,
  parameter int CNT_W      = 16
);
  logic                  EN_A, EN_B;
  logic                  TOK_A, TOK_B;
  logic                  FIFO_NEAR_FULL;
  logic [7:0]            SLICE_LEN;
  logic [READ_GAP_W-1:0] READ_GAP;
  logic                  FREEZE_A, FREEZE_B;
  logic                  READ_A, READ_B;
  logic                  SEL_B;
  logic                  CAPTURE;
  logic                  BUSY;
  logic [CNT_W-1:0]      FRAME_CNT, WORD_CNT;

  modport master (
    output EN_A, EN_B, TOK_A, TOK_B, FIFO_NEAR_FULL, SLICE_LEN, READ_GAP,
    input  FREEZE_A, FREEZE_B, READ_A, READ_B, SEL_B, CAPTURE, BUSY, FRAME_CNT, WORD_CNT
  );

  modport slave (
    input  EN_A, EN_B, TOK_A, TOK_B, FIFO_NEAR_FULL, SLICE_LEN, READ_GAP,
    output FREEZE_A, FREEZE_B, READ_A, READ_B, SEL_B, CAPTURE, BUSY, FRAME_CNT, WORD_CNT
  );
endinterface

// File: rtl/tjmono_rr2.sv
// Two-input round-robin arbiter; the registered bit remembers which half was served last.
module tjmono_rr2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req_a,
  input  logic i_req_b,
  input  logic i_upd,
  input  logic i_served_b,
  output logic o_grant_b
);
  logic r_last_b;

  // Reset to "B served last" so A wins the first contended grant.
  always_ff @(posedge i_clk) begin
    if (i_rst)      r_last_b <= 1'b1;
    else if (i_upd) r_last_b <= i_served_b;
  end

  assign o_grant_b = (i_req_a && i_req_b) ? ~r_last_b : i_req_b;
endmodule

// File: rtl/tjmono_ab_scheduler.sv
// Frame scheduler sharing one data receiver between chip halves A and B (freeze / read / capture).
module tjmono_ab_scheduler
  import tjmono_pkg::*;
#(
  parameter int READ_GAP_W = 6,
  parameter int CNT_W      = 16
) (
  input  logic CLK,
  input  logic RST,
  tjmono_ab_scheduler_if.slave bus
);
  localparam logic [READ_GAP_W-1:0] FRZ_LAST = READ_GAP_W'(FREEZE_SETUP - 1);
  localparam logic [READ_GAP_W-1:0] ONE      = READ_GAP_W'(1);

  sched_state_t          r_state;
  logic                  r_sel_b, r_frz_a, r_frz_b, r_rd_a, r_rd_b, r_cap, r_busy;
  logic [CNT_W-1:0]      r_frame_cnt, r_word_cnt;
  logic [FW_W-1:0]       r_fw_cnt;
  logic [READ_GAP_W-1:0] r_tmr;

  logic                  w_req_a, w_req_b, w_grant_b, w_rr_upd;
  logic                  w_sel_tok, w_sel_en, w_slice_done;
  logic [READ_GAP_W-1:0] w_gap;

  assign w_req_a      = bus.EN_A & bus.TOK_A;
  assign w_req_b      = bus.EN_B & bus.TOK_B;
  assign w_rr_upd     = (r_state == ST_UNFREEZE);
  assign w_sel_tok    = r_sel_b ? bus.TOK_B : bus.TOK_A;
  assign w_sel_en     = r_sel_b ? bus.EN_B  : bus.EN_A;
  assign w_slice_done = (bus.SLICE_LEN != 8'd0) && (r_fw_cnt == bus.SLICE_LEN);
  assign w_gap        = (bus.READ_GAP == '0) ? ONE : bus.READ_GAP;

  tjmono_rr2 u_rr (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_req_a    (w_req_a),
    .i_req_b    (w_req_b),
    .i_upd      (w_rr_upd),
    .i_served_b (r_sel_b),
    .o_grant_b  (w_grant_b)
  );

  // Outputs are registered together with the state they belong to.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_sel_b     <= 1'b0;
      r_frz_a     <= 1'b0;
      r_frz_b     <= 1'b0;
      r_rd_a      <= 1'b0;
      r_rd_b      <= 1'b0;
      r_cap       <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_cnt <= '0;
      r_word_cnt  <= '0;
      r_fw_cnt    <= '0;
      r_tmr       <= '0;
    end else begin
      r_rd_a <= 1'b0;
      r_rd_b <= 1'b0;
      r_cap  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!bus.FIFO_NEAR_FULL && (w_req_a || w_req_b)) begin
            r_state  <= ST_FREEZE;
            r_sel_b  <= w_grant_b;
            r_frz_a  <= ~w_grant_b;
            r_frz_b  <= w_grant_b;
            r_busy   <= 1'b1;
            r_tmr    <= '0;
            r_fw_cnt <= '0;
          end
        end
        ST_FREEZE: begin
          if (r_tmr == FRZ_LAST) begin
            r_state <= ST_READ_HI;
            r_rd_a  <= ~r_sel_b;
            r_rd_b  <= r_sel_b;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        ST_READ_HI: begin
          r_word_cnt <= r_word_cnt + 1'b1;
          if (r_fw_cnt != '1) r_fw_cnt <= r_fw_cnt + 1'b1;
          // Gap length is latched here, so a READ_GAP change only hits the next word.
          r_state <= ST_READ_LO;
          r_tmr   <= w_gap - 1'b1;
          r_cap   <= (w_gap == ONE);
        end
        ST_READ_LO: begin
          if (r_tmr == '0) begin
            r_state <= ST_DECIDE;
          end else begin
            r_tmr <= r_tmr - 1'b1;
            r_cap <= (r_tmr == ONE);
          end
        end
        ST_DECIDE: begin
          if (!w_sel_tok || !w_sel_en || w_slice_done) begin
            r_state <= ST_UNFREEZE;
            r_frz_a <= 1'b0;
            r_frz_b <= 1'b0;
          end else if (!bus.FIFO_NEAR_FULL) begin
            r_state <= ST_READ_HI;
            r_rd_a  <= ~r_sel_b;
            r_rd_b  <= r_sel_b;
          end
        end
        ST_UNFREEZE: begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_frz_a <= 1'b0;
          r_frz_b <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.FREEZE_A  = r_frz_a;
  assign bus.FREEZE_B  = r_frz_b;
  assign bus.READ_A    = r_rd_a;
  assign bus.READ_B    = r_rd_b;
  assign bus.SEL_B     = r_sel_b;
  assign bus.CAPTURE   = r_cap;
  assign bus.BUSY      = r_busy;
  assign bus.FRAME_CNT = r_frame_cnt;
  assign bus.WORD_CNT  = r_word_cnt;
endmodule

// File: tb/tb_tjmono_ab_scheduler.sv
// Directed + randomized bench for tjmono_ab_scheduler against a schedule-queue reference model.
module tb_tjmono_ab_scheduler;
  localparam int GW = 6;
  localparam int CW = 8;

  // Reference model: a queue of the expected per-cycle activity, extended at decision points.
  typedef enum int {K_IDLE, K_FRZ, K_RD, K_GAP, K_CAP, K_DEC, K_UNF} kind_t;
  typedef struct {
    kind_t kind;
    bit    sel;
  } item_t;

  logic CLK = 1'b0;
  logic RST;

  tjmono_ab_scheduler_if #(.READ_GAP_W(GW), .CNT_W(CW)) bus ();

  tjmono_ab_scheduler #(.READ_GAP_W(GW), .CNT_W(CW)) u_dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int    total = 0;
  int    bad   = 0;
  item_t q[$];
  item_t cur;
  int    m_words, m_frames, m_fw;
  bit    m_last_b;
  int    ncyc = 0;
  int    n_rd_a, n_rd_b, n_cap, n_busy, t_frz;
  int    t_rd[$];
  bit    starts[$];
  bit    prev_frz = 1'b0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, ncyc);
    end
  endtask

  task automatic push(kind_t k, bit s);
    item_t it;
    it.kind = k;
    it.sel  = s;
    q.push_back(it);
  endtask

  task automatic plan();
    bit ra, rb, g, tok, en;
    int gap;
    ra = bus.EN_A && bus.TOK_A;
    rb = bus.EN_B && bus.TOK_B;
    case (cur.kind)
      K_IDLE: begin
        if (!bus.FIFO_NEAR_FULL && (ra || rb)) begin
          g    = (ra && rb) ? !m_last_b : rb;
          m_fw = 0;
          push(K_FRZ, g); push(K_FRZ, g); push(K_RD, g);
        end else begin
          push(K_IDLE, cur.sel);
        end
      end
      K_RD: begin
        gap = (bus.READ_GAP == 0) ? 1 : int'(bus.READ_GAP);
        for (int i = 1; i < gap; i++) push(K_GAP, cur.sel);
        push(K_CAP, cur.sel);
        push(K_DEC, cur.sel);
        if (m_fw < 255) m_fw++;
      end
      K_DEC: begin
        tok = cur.sel ? bus.TOK_B : bus.TOK_A;
        en  = cur.sel ? bus.EN_B  : bus.EN_A;
        if (!tok || !en || (bus.SLICE_LEN != 0 && m_fw == int'(bus.SLICE_LEN))) push(K_UNF, cur.sel);
        else if (bus.FIFO_NEAR_FULL) push(K_DEC, cur.sel);
        else push(K_RD, cur.sel);
      end
      default: push(K_IDLE, cur.sel);
    endcase
  endtask

  task automatic check_outputs();
    bit f, rd;
    logic [6:0] exp, obs;
    f   = cur.kind inside {K_FRZ, K_RD, K_GAP, K_CAP, K_DEC};
    rd  = (cur.kind == K_RD);
    exp = {f && !cur.sel, f && cur.sel, rd && !cur.sel, rd && cur.sel,
           cur.sel, cur.kind == K_CAP, cur.kind != K_IDLE};
    obs = {bus.FREEZE_A, bus.FREEZE_B, bus.READ_A, bus.READ_B, bus.SEL_B, bus.CAPTURE, bus.BUSY};
    chk("outputs", 32'(obs), 32'(exp));
    chk("word_cnt", 32'(bus.WORD_CNT), 32'(m_words % (1 << CW)));
    chk("frame_cnt", 32'(bus.FRAME_CNT), 32'(m_frames % (1 << CW)));
    chk("onehot", 32'(!(bus.READ_A && bus.READ_B) && !(bus.FREEZE_A && bus.FREEZE_B)), 32'd1);
  endtask

  task automatic cyc();
    item_t nx;
    bit frz;
    if (RST) begin
      q.delete();
      m_words  = 0;
      m_frames = 0;
      m_last_b = 1'b1;
      nx.kind  = K_IDLE;
      nx.sel   = 1'b0;
    end else begin
      if (q.size() == 0) plan();
      nx = q.pop_front();
      if (cur.kind == K_RD) m_words++;
      if (cur.kind == K_UNF) begin
        m_frames++;
        m_last_b = cur.sel;
      end
    end
    @(posedge CLK);
    #1;
    cur = nx;
    ncyc++;
    check_outputs();
    if (bus.READ_A === 1'b1) begin n_rd_a++; t_rd.push_back(ncyc); end
    if (bus.READ_B === 1'b1) n_rd_b++;
    if (bus.CAPTURE === 1'b1) n_cap++;
    if (bus.BUSY === 1'b1) n_busy++;
    frz = (bus.FREEZE_A === 1'b1) || (bus.FREEZE_B === 1'b1);
    if (frz && !prev_frz) begin
      starts.push_back(bus.SEL_B);
      t_frz = ncyc;
    end
    prev_frz = frz;
  endtask

  task automatic clr();
    n_rd_a = 0; n_rd_b = 0; n_cap = 0; n_busy = 0; t_frz = 0;
    t_rd.delete();
    starts.delete();
  endtask

  task automatic quiet();
    bus.EN_A = 0; bus.EN_B = 0; bus.TOK_A = 0; bus.TOK_B = 0; bus.FIFO_NEAR_FULL = 0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    cyc();
    cyc();
    RST = 1'b0;
  endtask

  task automatic run_idle(string tag, int maxc);
    for (int n = 0; n < maxc && bus.BUSY !== 1'b0; n++) cyc();
    chk(tag, 32'(bus.BUSY), 32'd0);
  endtask

  initial begin
    cur.kind = K_IDLE;
    cur.sel  = 1'b0;
    quiet();
    bus.SLICE_LEN = 8'd0;
    bus.READ_GAP  = GW'(4);
    clr();

    // Reset state
    do_reset();
    chk("rst_busy", 32'(bus.BUSY), 32'd0);

    // Single requester A, 3 words, READ_GAP=4
    clr();
    bus.EN_A = 1; bus.TOK_A = 1;
    for (int i = 0; i < 100 && n_rd_a < 3; i++) cyc();
    bus.TOK_A = 0;
    run_idle("a3_end", 50);
    chk("a3_reads", 32'(n_rd_a), 32'd3);
    chk("a3_caps", 32'(n_cap), 32'd3);
    chk("a3_frames", 32'(bus.FRAME_CNT), 32'd1);
    chk("a3_words", 32'(bus.WORD_CNT), 32'd3);
    if (t_rd.size() == 3) begin
      chk("a3_frz_setup", 32'(t_rd[0] - t_frz), 32'd2);
      chk("a3_low_gap", 32'(t_rd[1] - t_rd[0] - 1), 32'd5);
      chk("a3_low_gap2", 32'(t_rd[2] - t_rd[1] - 1), 32'd5);
    end

    // Both tokens, SLICE_LEN=2: round-robin A,B,A,B
    do_reset();
    clr();
    bus.SLICE_LEN = 8'd2;
    bus.READ_GAP  = GW'($urandom_range(1, 3));
    bus.EN_A = 1; bus.EN_B = 1; bus.TOK_A = 1; bus.TOK_B = 1;
    for (int i = 0; i < 300 && starts.size() < 5; i++) cyc();
    bus.TOK_A = 0; bus.TOK_B = 0;
    run_idle("rr_end", 50);
    chk("rr_nframes", 32'(starts.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < starts.size(); i++)
      chk($sformatf("rr_sel%0d", i), 32'(starts[i]), 32'(i % 2));

    // Backpressure: stall after the first word, then no start while near-full in IDLE
    clr();
    bus.SLICE_LEN = 8'd0;
    bus.READ_GAP  = GW'(2);
    bus.EN_B = 0; bus.TOK_A = 1;
    for (int i = 0; i < 50 && n_rd_a < 1; i++) cyc();
    bus.FIFO_NEAR_FULL = 1;
    n_rd_a = 0;
    for (int i = 0; i < 10; i++) cyc();
    chk("nf_no_read", 32'(n_rd_a), 32'd0);
    bus.FIFO_NEAR_FULL = 0;
    for (int i = 0; i < 12; i++) cyc();
    chk("nf_resume", 32'(n_rd_a > 0), 32'd1);
    bus.TOK_A = 0;
    run_idle("nf_end", 50);
    bus.FIFO_NEAR_FULL = 1; bus.TOK_A = 1;
    n_busy = 0;
    for (int i = 0; i < 6; i++) cyc();
    chk("nf_idle_hold", 32'(n_busy), 32'd0);
    bus.FIFO_NEAR_FULL = 0; bus.TOK_A = 0;
    cyc();

    // EN_A cleared during READ_LO
    clr();
    bus.READ_GAP = GW'(3);
    bus.TOK_A = 1;
    for (int i = 0; i < 60 && n_rd_a < 2; i++) cyc();
    cyc();
    bus.EN_A = 0;
    run_idle("en_end", 50);
    chk("en_reads", 32'(n_rd_a), 32'd2);
    chk("en_caps", 32'(n_cap), 32'd2);

    // Reset during READ_HI, then A wins the next contended grant
    do_reset();
    clr();
    bus.EN_A = 1; bus.TOK_A = 1;
    for (int i = 0; i < 50 && n_rd_a < 1; i++) cyc();
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    chk("rhi_frz", 32'({bus.FREEZE_A, bus.READ_A}), 32'd0);
    chk("rhi_frames", 32'(bus.FRAME_CNT), 32'd0);
    starts.delete();
    bus.EN_B = 1; bus.TOK_B = 1;
    for (int i = 0; i < 20 && starts.size() < 1; i++) cyc();
    chk("rhi_grant_a", 32'(starts.size() == 1 && starts[0] == 1'b0), 32'd1);
    bus.TOK_A = 0; bus.TOK_B = 0;
    run_idle("rhi_end", 60);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(15) == 0) bus.EN_A = ~bus.EN_A;
      if ($urandom_range(15) == 0) bus.EN_B = ~bus.EN_B;
      if ($urandom_range(5) == 0)  bus.TOK_A = ~bus.TOK_A;
      if ($urandom_range(5) == 0)  bus.TOK_B = ~bus.TOK_B;
      bus.FIFO_NEAR_FULL = ($urandom_range(3) == 0);
      if ($urandom_range(19) == 0) bus.READ_GAP  = GW'($urandom_range(0, 5));
      if ($urandom_range(19) == 0) bus.SLICE_LEN = 8'($urandom_range(0, 3));
      RST = ($urandom_range(199) == 0);
      cyc();
    end
    RST = 1'b0;
    quiet();
    run_idle("rand_end", 100);

    // Counter wrap: 2^CW words in one frame, then 2^CW frames
    do_reset();
    clr();
    bus.SLICE_LEN = 8'd0;
    bus.READ_GAP  = GW'(1);
    bus.EN_A = 1; bus.TOK_A = 1;
    for (int i = 0; i < 1200 && n_rd_a < (1 << CW); i++) cyc();
    bus.TOK_A = 0;
    run_idle("wrap_w_end", 20);
    chk("word_wrap", 32'(bus.WORD_CNT), 32'd0);
    do_reset();
    clr();
    bus.SLICE_LEN = 8'd1;
    bus.TOK_A = 1;
    for (int i = 0; i < 3000 && starts.size() < (1 << CW); i++) cyc();
    bus.TOK_A = 0;
    run_idle("wrap_f_end", 20);
    chk("frame_wrap", 32'(bus.FRAME_CNT), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
